// File: rtl/significand_div.sv
// Radix-2 restoring divider for 11-bit significands: q = floor(({azero,a} << FRAC_BITS) / {bzero,b}).
// Optional SDIV_STICKY_EN adds a sticky output (final remainder nonzero) for the rounding stage.
module significand_div #(
  parameter int FRAC_BITS = 12,
  localparam int QW = 11 + FRAC_BITS
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [9:0]    a,
  input  logic          azero,
  input  logic [9:0]    b,
  input  logic          bzero,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] q,
  output logic          dz
`ifdef SDIV_STICKY_EN
  ,
  output logic          sticky
`endif
);

  localparam int CW = $clog2(QW + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic          r_busy;
  logic          r_done;
  logic [QW-1:0] r_q;
  logic          r_dz;
  logic [11:0]   r_rem;
  logic [CW-1:0] r_cnt;
  logic [QW-1:0] r_div;
  logic [10:0]   r_d;
`ifdef SDIV_STICKY_EN
  logic          r_sticky;
`endif

  logic [10:0]   w_d_in;
  logic [11:0]   w_t;
  logic [11:0]   w_rem_nxt;
  logic          w_bit;

  assign w_d_in = {bzero, b};

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  always_comb begin
    w_t       = {r_rem[10:0], r_div[QW-1]};
    w_rem_nxt = w_t;
    w_bit     = 1'b0;
    if (w_t >= {1'b0, r_d}) begin
      w_rem_nxt = w_t - {1'b0, r_d};
      w_bit     = 1'b1;
    end else begin
      w_rem_nxt = w_t;
      w_bit     = 1'b0;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_q      <= '0;
      r_dz     <= 1'b0;
      r_rem    <= 12'd0;
      r_cnt    <= '0;
      r_div    <= '0;
      r_d      <= 11'd0;
`ifdef SDIV_STICKY_EN
      r_sticky <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (w_d_in == 11'd0) begin
              // Divide by zero saturates immediately without entering RUN.
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_q      <= '1;
              r_dz     <= 1'b1;
`ifdef SDIV_STICKY_EN
              r_sticky <= 1'b0;
`endif
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_q     <= '0;
              r_dz    <= 1'b0;
              r_rem   <= 12'd0;
              r_cnt   <= CW'(QW - 1);
              r_div   <= {azero, a, {FRAC_BITS{1'b0}}};
              r_d     <= w_d_in;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[QW-2:0], w_bit};
          r_div <= {r_div[QW-2:0], 1'b0};
          if (r_cnt == '0) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_dz     <= 1'b0;
`ifdef SDIV_STICKY_EN
            r_sticky <= (w_rem_nxt != 12'd0);
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_rem   <= 12'd0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign q    = r_q;
  assign dz   = r_dz;
`ifdef SDIV_STICKY_EN
  assign sticky = r_sticky;
`endif

endmodule

// File: tb/tb_significand_div.sv
// Self-checking bench for significand_div: directed cases, random operands against an arithmetic model.
module tb_significand_div;

  localparam int FRAC_BITS = 12;
  localparam int QW = 11 + FRAC_BITS;
  localparam int ITER = QW;

  logic          CLK;
  logic          RST;
  logic          start;
  logic [9:0]    a;
  logic          azero;
  logic [9:0]    b;
  logic          bzero;
  logic          busy;
  logic          done;
  logic [QW-1:0] q;
  logic          dz;
  logic          st_dut;

  int n_tests = 0;
  int n_fail  = 0;

  logic [QW-1:0] exp_q_q[$];
  logic          exp_dz_q[$];
  logic          exp_st_q[$];

  significand_div #(.FRAC_BITS(FRAC_BITS)) dut (
    .CLK(CLK), .RST(RST), .start(start), .a(a), .azero(azero), .b(b), .bzero(bzero),
    .busy(busy), .done(done), .q(q), .dz(dz)
`ifdef SDIV_STICKY_EN
    , .sticky(st_dut)
`endif
  );

`ifndef SDIV_STICKY_EN
  assign st_dut = 1'b0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division of the scaled dividend; returns {q, sticky}.
  function automatic logic [QW:0] model(input logic [9:0] ma, input logic maz,
                                        input logic [9:0] mb, input logic mbz);
    longint n, d, qq, rr;
    n = longint'({maz, ma}) * (longint'(1) << FRAC_BITS);
    d = longint'({mbz, mb});
    if (d == 0) return {{QW{1'b1}}, 1'b0};
    qq = n / d;
    rr = n % d;
    return {qq[QW-1:0], (rr != 0)};
  endfunction

  // Compare process: every done cycle must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (RST && done) begin
      if (exp_q_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_done: done seen with no operation pending at %0t", $time);
      end else begin
        logic [QW-1:0] eq;
        logic edz, est;
        eq  = exp_q_q.pop_front();
        edz = exp_dz_q.pop_front();
        est = exp_st_q.pop_front();
        chk("q", 64'(q), 64'(eq));
        chk("dz", 64'(dz), 64'(edz));
`ifdef SDIV_STICKY_EN
        chk("sticky", 64'(st_dut), 64'(est));
`endif
      end
    end
  end

  task automatic do_op(input logic [9:0] ia, input logic iaz, input logic [9:0] ib, input logic ibz,
                       input logic [QW-1:0] eq, input logic edz, input logic est, input int mid);
    int lat;
    int exp_lat;
    a = ia; azero = iaz; b = ib; bzero = ibz;
    start = 1'b1;
    exp_q_q.push_back(eq);
    exp_dz_q.push_back(edz);
    exp_st_q.push_back(est);
    exp_lat = ({ibz, ib} == 11'd0) ? 0 : ITER;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      chk("busy_run", 64'(busy), 64'd1);
      if (lat == mid) begin
        start = 1'b1; a = 10'h3FF; azero = 1'b1; b = 10'h001; bzero = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge CLK); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_at_done", 64'(busy), 64'd0);
    @(posedge CLK); #1;
    chk("done_pulse", 64'(done), 64'd0);
    chk("q_hold", 64'(q), 64'(eq));
    chk("dz_hold", 64'(dz), 64'(edz));
  endtask

  initial begin
    logic [QW:0] m;
    logic [9:0] ra, rb;
    logic raz, rbz;

    RST = 1'b0; start = 1'b0; a = 10'd0; azero = 1'b0; b = 10'd0; bzero = 1'b0;

    // Pin the model against hand-computed values.
    m = model(10'h000, 1'b1, 10'h000, 1'b1); chk("model_1_1", 64'(m), 64'({23'h001000, 1'b0}));
    m = model(10'h200, 1'b1, 10'h000, 1'b1); chk("model_15_1", 64'(m), 64'({23'h001800, 1'b0}));
    m = model(10'h000, 1'b1, 10'h200, 1'b1); chk("model_1_15", 64'(m), 64'({23'h000AAA, 1'b1}));
    m = model(10'h005, 1'b1, 10'h000, 1'b0); chk("model_dz", 64'(m), 64'({23'h7FFFFF, 1'b0}));

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    do_op(10'h000, 1'b1, 10'h000, 1'b1, 23'h001000, 1'b0, 1'b0, -1);
    do_op(10'h200, 1'b1, 10'h000, 1'b1, 23'h001800, 1'b0, 1'b0, -1);
    do_op(10'h000, 1'b1, 10'h200, 1'b1, 23'h000AAA, 1'b0, 1'b1, -1);
    do_op(10'h005, 1'b1, 10'h000, 1'b0, 23'h7FFFFF, 1'b1, 1'b0, -1);
    do_op(10'h001, 1'b0, 10'h000, 1'b1, 23'h000004, 1'b0, 1'b0, 4);
    do_op(10'h3FF, 1'b1, 10'h001, 1'b0, 23'h7FF000, 1'b0, 1'b0, -1);

    // Abort mid-operation with an asynchronous reset.
    a = 10'h000; azero = 1'b1; b = 10'h000; bzero = 1'b1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_q", 64'(q), 64'd0);
    chk("abort_dz", 64'(dz), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    do_op(10'h000, 1'b1, 10'h000, 1'b1, 23'h001000, 1'b0, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      ra  = 10'($urandom_range(0, 1023));
      raz = 1'($urandom_range(0, 1));
      rb  = 10'($urandom_range(0, 1023));
      rbz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        rb = 10'd0; rbz = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) rb = 10'($urandom_range(0, 3));
      m = model(ra, raz, rb, rbz);
      do_op(ra, raz, rb, rbz, m[QW:1], ({rbz, rb} == 11'd0), m[0], int'($urandom_range(0, 30)));
    end

    repeat (5) @(posedge CLK);
    chk("no_pending", 64'(exp_q_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
